// File: rtl/acc_pkg.sv
// Shared definitions for the matrix accelerator front end: sequencer states,
// PPU mode encodings and the operand widths used by matrix_accelerator.
package acc_pkg;

    localparam int ACC_A_WIDTH = 4224;
    localparam int ACC_B_WIDTH = 264;

    localparam logic [1:0] MODE_SOFTMAX = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_PPU = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mac_operand_sequencer_seq_cycle_counter.sv
// Loadable up/down counter with a terminal-count flag; load has priority over enable.
module seq_cycle_counter #(
    parameter int               WIDTH    = 5,
    parameter bit               COUNT_UP = 1'b1,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en) begin
            count_reg <= COUNT_UP ? count_reg + 1'b1 : count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == TERMINAL);

endmodule

// File: rtl/mac_operand_sequencer.sv
// Job front end for matrix_accelerator: fetches one operand pair per K-tile, issues
// CALC_COUNT MAC cycles per tile, then waits for the PPU completion or a timeout.
module mac_operand_sequencer
    import acc_pkg::*;
#(
    parameter int A_WIDTH        = ACC_A_WIDTH,
    parameter int B_WIDTH        = ACC_B_WIDTH,
    parameter int CALC_COUNT     = 32,
    parameter int CALC_BIT_WIDTH = 5,
    parameter int TILE_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [TILE_W-1:0]  cmd_tiles,
    input  logic [1:0]         cmd_mode,
    input  logic               cmd_int8,
    input  logic               cmd_int4,
    input  logic               cmd_vsq,
    input  logic [7:0]         cmd_scale_a,
    input  logic [7:0]         cmd_scale_w,
    input  logic [7:0]         cmd_bias,
    output logic               op_req,
    input  logic               op_valid,
    input  logic [A_WIDTH-1:0] op_a,
    input  logic [B_WIDTH-1:0] op_b,
    output logic [A_WIDTH-1:0] a_vec,
    output logic [B_WIDTH-1:0] b_vec,
    output logic [1:0]         mode,
    output logic               is_int8_mode,
    output logic               is_int4_mode,
    output logic               is_vsq,
    output logic [7:0]         scale_a,
    output logic [7:0]         scale_w,
    output logic [7:0]         bias,
    output logic               valid_mac,
    output logic               valid_ppu,
    input  logic               q_done,
    input  logic               s_done,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    seq_state_t state_reg, state_next;
    logic       accept, capture, ppu_event;
    logic       done_next, err_next;
    logic       calc_tc, tile_tc, timeout_tc;

    assign accept  = (state_reg == IDLE) && cmd_valid;
    assign capture = (state_reg == FETCH) && op_valid;
    // Softmax jobs finish on s_done; every other mode finishes on q_done.
    assign ppu_event = (mode == MODE_SOFTMAX) ? s_done : q_done;

    seq_cycle_counter #(
        .WIDTH    (CALC_BIT_WIDTH),
        .COUNT_UP (1'b1),
        .TERMINAL (CALC_BIT_WIDTH'(CALC_COUNT - 1))
    ) u_calc_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (state_reg != ISSUE),
        .load_value ('0),
        .en         (state_reg == ISSUE),
        .tc         (calc_tc)
    );

    // Holds tiles still to issue; terminal count marks the last tile of the job.
    seq_cycle_counter #(
        .WIDTH    (TILE_W),
        .COUNT_UP (1'b0),
        .TERMINAL (TILE_W'(1))
    ) u_tile_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value ((cmd_tiles == '0) ? TILE_W'(1) : cmd_tiles),
        .en         ((state_reg == ISSUE) && calc_tc),
        .tc         (tile_tc)
    );

    seq_cycle_counter #(
        .WIDTH    (TO_W),
        .COUNT_UP (1'b1),
        .TERMINAL (TO_W'(TIMEOUT_CYCLES - 1))
    ) u_timeout_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (state_reg != WAIT_PPU),
        .load_value ('0),
        .en         (state_reg == WAIT_PPU),
        .tc         (timeout_tc)
    );

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE:     if (cmd_valid) state_next = FETCH;
            FETCH:    if (op_valid) state_next = ISSUE;
            ISSUE:    if (calc_tc) state_next = tile_tc ? WAIT_PPU : FETCH;
            WAIT_PPU: begin
                // A completion arriving on the expiry cycle still counts as done.
                if (ppu_event) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (timeout_tc) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            op_req      <= 1'b0;
            valid_mac   <= 1'b0;
            valid_ppu   <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            cmd_ready   <= (state_next == IDLE);
            busy        <= (state_next != IDLE);
            op_req      <= (state_next == FETCH);
            valid_mac   <= (state_next == ISSUE);
            valid_ppu   <= (state_next == WAIT_PPU);
            done        <= done_next;
            err_timeout <= err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode         <= '0;
            is_int8_mode <= 1'b0;
            is_int4_mode <= 1'b0;
            is_vsq       <= 1'b0;
            scale_a      <= '0;
            scale_w      <= '0;
            bias         <= '0;
            a_vec        <= '0;
            b_vec        <= '0;
        end else begin
            if (accept) begin
                mode         <= cmd_mode;
                is_int8_mode <= cmd_int8;
                is_int4_mode <= cmd_int4 & ~cmd_int8;
                is_vsq       <= cmd_vsq;
                scale_a      <= cmd_scale_a;
                scale_w      <= cmd_scale_w;
                bias         <= cmd_bias;
            end
            if (capture) begin
                a_vec <= op_a;
                b_vec <= op_b;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomised job stream against mac_operand_sequencer; a negedge monitor scores
// every MAC burst and every job completion against expectations queued by the stimulus.
module tb_mac_operand_sequencer;
    import acc_pkg::*;

    localparam int AW = 4224;
    localparam int BW = 264;
    localparam int CC = 32;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [7:0]    cmd_tiles;
    logic [1:0]    cmd_mode;
    logic          cmd_int8, cmd_int4, cmd_vsq;
    logic [7:0]    cmd_scale_a, cmd_scale_w, cmd_bias;
    logic          op_req, op_valid;
    logic [AW-1:0] op_a, a_vec;
    logic [BW-1:0] op_b, b_vec;
    logic [1:0]    mode;
    logic          is_int8_mode, is_int4_mode, is_vsq;
    logic [7:0]    scale_a, scale_w, bias;
    logic          valid_mac, valid_ppu, q_done, s_done, busy, done, err_timeout;

    mac_operand_sequencer #(
        .A_WIDTH(AW), .B_WIDTH(BW), .CALC_COUNT(CC), .CALC_BIT_WIDTH(5),
        .TILE_W(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tiles(cmd_tiles),
        .cmd_mode(cmd_mode), .cmd_int8(cmd_int8), .cmd_int4(cmd_int4), .cmd_vsq(cmd_vsq),
        .cmd_scale_a(cmd_scale_a), .cmd_scale_w(cmd_scale_w), .cmd_bias(cmd_bias),
        .op_req(op_req), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .a_vec(a_vec), .b_vec(b_vec), .mode(mode),
        .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq),
        .scale_a(scale_a), .scale_w(scale_w), .bias(bias),
        .valid_mac(valid_mac), .valid_ppu(valid_ppu),
        .q_done(q_done), .s_done(s_done),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tiles;
        bit         timeout;
        int         wait_cycles;
        int         busy_cycles;
        logic [1:0] mode;
        logic       int8, int4, vsq;
        logic [7:0] sa, sw, bias;
    } job_t;

    job_t          job_q[$];
    int            op_delay_q[$];
    logic [AW-1:0] op_a_q[$], exp_a_q[$];
    logic [BW-1:0] op_b_q[$], exp_b_q[$];

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_vec(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got ..%h, expected ..%h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endfunction

    function automatic logic [AW-1:0] rand_a();
        logic [AW-1:0] v = '0;
        for (int i = 0; i <= AW / 32; i++) v = (v << 32) | AW'($urandom);
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_b();
        logic [BW-1:0] v = '0;
        for (int i = 0; i <= BW / 32; i++) v = (v << 32) | BW'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Random command traffic while the sequencer is busy; none of it may be taken.
    task automatic cmd_noise();
        cmd_valid   = ($urandom_range(0, 2) == 0);
        cmd_tiles   = 8'($urandom);
        cmd_mode    = 2'($urandom);
        cmd_int8    = 1'($urandom);
        cmd_int4    = 1'($urandom);
        cmd_vsq     = 1'($urandom);
        cmd_scale_a = 8'($urandom);
        cmd_scale_w = 8'($urandom);
        cmd_bias    = 8'($urandom);
    endtask

    // Queue the plan for one job; returns after the handshake.
    task automatic issue_job(input int tiles_raw, input logic [1:0] md, input logic i8,
                             input logic i4, input bit tmo, input int fix_d, input int ev,
                             input bit record);
        job_t          j;
        int            t, d, n;
        bit            hs;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        t = (tiles_raw == 0) ? 1 : tiles_raw;
        j.busy_cycles = 0;
        for (int k = 0; k < t; k++) begin
            d = (fix_d >= 0) ? fix_d : $urandom_range(0, 4);
            a = rand_a();
            b = rand_b();
            op_delay_q.push_back(d);
            op_a_q.push_back(a);
            op_b_q.push_back(b);
            exp_a_q.push_back(a);
            exp_b_q.push_back(b);
            j.busy_cycles += d + 1 + CC;
        end
        j.tiles       = t;
        j.timeout     = tmo;
        j.wait_cycles = tmo ? TO : ev + 1;
        j.busy_cycles += j.wait_cycles;
        j.mode = md;
        j.int8 = i8;
        j.int4 = i4 && !i8;
        j.vsq  = 1'($urandom);
        j.sa   = 8'($urandom);
        j.sw   = 8'($urandom);
        j.bias = 8'($urandom);
        if (record) job_q.push_back(j);
        cmd_valid   = 1'b1;
        cmd_tiles   = 8'(tiles_raw);
        cmd_mode    = md;
        cmd_int8    = i8;
        cmd_int4    = i4;
        cmd_vsq     = j.vsq;
        cmd_scale_a = j.sa;
        cmd_scale_w = j.sw;
        cmd_bias    = j.bias;
        n = 0;
        do begin
            hs = cmd_ready;
            step();
            n++;
        end while (!hs && n < 20);
        if (!hs) begin
            chk("cmd_handshake", 0, 1);
            finish_sim();
        end
    endtask

    task automatic run_job(input int tiles_raw, input logic [1:0] md, input logic i8,
                           input logic i4, input bit tmo, input int fix_d, input int ev);
        int n;
        issue_job(tiles_raw, md, i8, i4, tmo, fix_d, ev, 1'b1);
        n = 0;
        while (!valid_ppu && n < 1000) begin
            cmd_noise();
            q_done = ($urandom_range(0, 5) == 0);
            s_done = ($urandom_range(0, 5) == 0);
            step();
            n++;
        end
        if (!valid_ppu) begin
            chk("reach_wait_ppu", 0, 1);
            finish_sim();
        end
        // In WAIT_PPU: the wrong-type pulse at offset 0 must be ignored.
        for (int k = 0; k < 2000; k++) begin
            if (done || err_timeout) break;
            cmd_noise();
            q_done = 1'b0;
            s_done = 1'b0;
            if (!tmo && k == ev) begin
                if (md == MODE_SOFTMAX) s_done = 1'b1; else q_done = 1'b1;
            end else if (k == 0) begin
                if (md == MODE_SOFTMAX) q_done = 1'b1; else s_done = 1'b1;
            end
            step();
        end
        q_done    = 1'b0;
        s_done    = 1'b0;
        cmd_valid = 1'b0;
        if (!(done || err_timeout)) begin
            chk("job_completion", 0, 1);
            finish_sim();
        end
        repeat ($urandom_range(0, 2)) step();
    endtask

    // Operand source: honours the planned latency for each request, and
    // throws spurious op_valid pulses while no request is outstanding.
    initial begin
        int d;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        forever begin
            step();
            if (op_req && op_delay_q.size() > 0) begin
                d = op_delay_q.pop_front();
                op_valid = 1'b0;
                repeat (d) step();
                op_valid = 1'b1;
                op_a = op_a_q.pop_front();
                op_b = op_b_q.pop_front();
                step();
                op_valid = 1'b0;
                op_a = rand_a();
                op_b = rand_b();
            end else begin
                op_valid = !op_req && ($urandom_range(0, 3) == 0);
                if (op_valid) begin
                    op_a = rand_a();
                    op_b = rand_b();
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int            m_bursts, m_run, m_hs, m_busy, m_ppu, m_jobs;
        bit            m_prev_mac, m_unstable, m_overlap, m_rst_seen;
        logic [AW-1:0] m_a;
        logic [BW-1:0] m_b;
        job_t          j;
        m_bursts = 0; m_run = 0; m_hs = 0; m_busy = 0; m_ppu = 0; m_jobs = 0;
        m_prev_mac = 0; m_unstable = 0; m_overlap = 0; m_rst_seen = 0;
        m_a = '0;
        m_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!m_rst_seen) begin
                    chk("reset_ctrl", {cmd_ready, op_req, valid_mac, valid_ppu, busy, done, err_timeout},
                        7'b1000000);
                    chk("reset_fields", {mode, is_int8_mode, is_int4_mode, is_vsq, scale_a, scale_w, bias}, 0);
                    chk("reset_vec", {63'd0, (|a_vec) | (|b_vec)}, 0);
                end
                m_rst_seen = 1;
                m_bursts = 0; m_run = 0; m_hs = 0; m_busy = 0; m_ppu = 0;
                m_prev_mac = 0; m_unstable = 0; m_overlap = 0;
            end else begin
                m_rst_seen = 0;
                if (busy) m_busy++;
                if (valid_ppu) m_ppu++;
                if (valid_mac && valid_ppu) m_overlap = 1;
                if (op_req && op_valid) m_hs++;
                if (valid_mac && !m_prev_mac) begin
                    if (exp_a_q.size() == 0) begin
                        chk("operand_expected", 0, 1);
                    end else begin
                        m_a = exp_a_q.pop_front();
                        m_b = exp_b_q.pop_front();
                        chk_vec("a_vec", a_vec, m_a);
                        chk_vec("b_vec", AW'(b_vec), AW'(m_b));
                    end
                    m_run = 1;
                    m_unstable = 0;
                end else if (valid_mac) begin
                    m_run++;
                    if (a_vec !== m_a || b_vec !== m_b) m_unstable = 1;
                end else if (m_prev_mac) begin
                    chk("mac_burst_len", m_run, CC);
                    chk("operands_stable", m_unstable, 0);
                    m_bursts++;
                end
                m_prev_mac = valid_mac;
                if (done || err_timeout) begin
                    if (job_q.size() == 0) begin
                        chk("unexpected_completion", {done, err_timeout}, 0);
                    end else begin
                        j = job_q.pop_front();
                        chk("outcome", {done, err_timeout}, j.timeout ? 2'b01 : 2'b10);
                        chk("busy_cycles", m_busy, j.busy_cycles);
                        chk("wait_ppu_cycles", m_ppu, j.wait_cycles);
                        chk("mac_bursts", m_bursts, j.tiles);
                        chk("op_handshakes", m_hs, j.tiles);
                        chk("job_fields", {mode, is_int8_mode, is_int4_mode, is_vsq, scale_a, scale_w, bias},
                            {j.mode, j.int8, j.int4, j.vsq, j.sa, j.sw, j.bias});
                        chk("mac_ppu_exclusive", m_overlap, 0);
                        chk("ready_after_job", {cmd_ready, busy}, 2'b10);
                        $display("job %0d: tiles=%0d mode=%0d %s busy=%0d wait=%0d",
                                 m_jobs, j.tiles, j.mode, done ? "done" : "timeout", m_busy, m_ppu);
                        m_jobs++;
                    end
                    m_bursts = 0; m_hs = 0; m_busy = 0; m_ppu = 0; m_overlap = 0;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_tiles = '0; cmd_mode = '0; cmd_int8 = 1'b0; cmd_int4 = 1'b0;
        cmd_vsq = 1'b0; cmd_scale_a = '0; cmd_scale_w = '0; cmd_bias = '0;
        q_done = 1'b0; s_done = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        run_job(1, 2'b00, 1'b0, 1'b0, 1'b0, 3, 5);     // busy = 1+3+32+5+1
        run_job(3, 2'b01, 1'b0, 1'b0, 1'b0, -1, 2);
        run_job(2, MODE_SOFTMAX, 1'b1, 1'b0, 1'b0, -1, 4);
        run_job(1, 2'b00, 1'b0, 1'b1, 1'b1, -1, 0);    // timeout
        run_job(0, 2'b11, 1'b1, 1'b1, 1'b0, -1, 1);    // zero tiles, int8 wins
        for (int i = 0; i < 16; i++) begin
            run_job($urandom_range(0, 4), 2'($urandom), 1'($urandom), 1'($urandom),
                    1'b0, -1, $urandom_range(0, 8));
        end
        run_job(2, MODE_SOFTMAX, 1'b0, 1'b1, 1'b1, -1, 0);

        // Reset in the middle of the first MAC burst of a two-tile job.
        issue_job(2, 2'b01, 1'b0, 1'b0, 1'b0, 1, 3, 1'b0);
        cmd_valid = 1'b0;
        n = 0;
        while (!valid_mac && n < 100) begin
            step();
            n++;
        end
        chk("reach_issue", valid_mac, 1);
        repeat (10) step();
        rst = 1'b1;
        op_delay_q.delete(); op_a_q.delete(); op_b_q.delete();
        exp_a_q.delete(); exp_b_q.delete();
        step();
        step();
        rst = 1'b0;
        repeat (40) step();

        run_job(2, 2'b00, 1'b0, 1'b0, 1'b0, -1, 3);
        repeat (3) step();
        chk("jobs_outstanding", job_q.size(), 0);
        finish_sim();
    end

endmodule
